// File: rtl/bmu_writeback_buffer_pkg.sv
// Shared types for the BMU writeback result buffer.
// Entry layout and default buffer geometry.
package apogeo_pkg;

    typedef logic [31:0] data_word_t;

    localparam int BMU_WB_DEPTH     = 4;
    localparam int BMU_WB_TAG_WIDTH = 6;

    typedef struct packed {
        data_word_t                  result;
        logic [4:0]                  dest;
        logic [BMU_WB_TAG_WIDTH-1:0] tag;
    } bmu_wb_entry_t;

endpackage

// File: rtl/bmu_writeback_buffer_if.sv
// Valid/ready link from the BMU result buffer to the writeback arbiter.
// The buffer is the master; the arbiter is the slave.
interface bmu_writeback_buffer_if
    import apogeo_pkg::*;
#(
    parameter int TAG_WIDTH = BMU_WB_TAG_WIDTH
);

    data_word_t           wb_result_o;
    logic [TAG_WIDTH-1:0] wb_tag_o;
    logic [4:0]           wb_dest_o;
    logic                 wb_valid_o;
    logic                 wb_ready_i;

    modport master (
        output wb_result_o,
        output wb_tag_o,
        output wb_dest_o,
        output wb_valid_o,
        input  wb_ready_i
    );

    modport slave (
        input  wb_result_o,
        input  wb_tag_o,
        input  wb_dest_o,
        input  wb_valid_o,
        output wb_ready_i
    );

endinterface

// File: rtl/bmu_writeback_buffer_storage.sv
// Entry array with wrapping read/write pointers for the BMU result buffer.
// The data array carries no reset; validity is tracked by the parent's count.
module bmu_writeback_buffer_storage
    import apogeo_pkg::*;
#(
    parameter int  DEPTH   = BMU_WB_DEPTH,
    parameter type entry_t = bmu_wb_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  logic   clear_i,
    input  logic   we_i,
    input  entry_t wdata_i,
    input  logic   re_i,
    output entry_t rdata_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (we_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (re_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    assign rdata_o = mem[rd_ptr_q];

endmodule

// File: rtl/bmu_writeback_buffer.sv
// BMU result buffer feeding the integer writeback arbiter; throttles the BMU.
// Define BMU_WB_BYPASS_EN to forward results straight through when empty.
module bmu_writeback_buffer
    import apogeo_pkg::*;
#(
    parameter int DEPTH     = BMU_WB_DEPTH,
    parameter int TAG_WIDTH = BMU_WB_TAG_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   clear_i,
    input  logic                   stall_i,
    input  data_word_t             bmu_result_i,
    input  logic                   bmu_valid_i,
    input  logic [TAG_WIDTH-1:0]   bmu_tag_i,
    input  logic [4:0]             bmu_dest_i,
    output logic                   bmu_clk_en_o,
    bmu_writeback_buffer_if.master wb,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] EN_LIM   = (AW+2)'(DEPTH - 1);

    typedef struct packed {
        data_word_t           result;
        logic [4:0]           dest;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          fresh_q;
    logic          clear_hold_q;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          wr_en;
    logic          rd_en;
    logic [AW+1:0] occ;
    entry_t        wr_entry;
    entry_t        rd_entry;

    // A held BMU output is only new if the stage advanced on the last edge.
    assign push = bmu_valid_i & fresh_q & ~clear_i;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);

`ifdef BMU_WB_BYPASS_EN
    assign bypass = empty_o & push & wb.wb_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign wb.wb_valid_o = ~empty_o | bypass;
    assign pop   = wb.wb_valid_o & wb.wb_ready_i & ~clear_i;
    assign wr_en = push & ~bypass;
    assign rd_en = pop & ~empty_o;

    assign wr_entry = '{
        result: bmu_result_i,
        dest:   bmu_dest_i,
        tag:    bmu_tag_i
    };

    bmu_writeback_buffer_storage #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_storage (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (clear_i),
        .we_i    (wr_en),
        .wdata_i (wr_entry),
        .re_i    (rd_en),
        .rdata_o (rd_entry)
    );

    assign wb.wb_result_o = bypass ? bmu_result_i : rd_entry.result;
    assign wb.wb_dest_o   = bypass ? bmu_dest_i   : rd_entry.dest;
    assign wb.wb_tag_o    = bypass ? bmu_tag_i    : rd_entry.tag;

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // One slot stays free for the result the advancing BMU will produce.
    assign occ = {1'b0, count_q} + {{(AW+1){1'b0}}, push};
    assign bmu_clk_en_o = ~stall_i & ~clear_hold_q & (occ <= EN_LIM);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q      <= '0;
            fresh_q      <= 1'b0;
            clear_hold_q <= 1'b0;
        end else if (clear_i) begin
            count_q      <= '0;
            fresh_q      <= 1'b0;
            clear_hold_q <= 1'b1;
        end else begin
            count_q      <= count_d;
            fresh_q      <= bmu_clk_en_o;
            clear_hold_q <= 1'b0;
        end
    end

    a_no_push_full: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        !(push && full_o && !pop)
    );

endmodule

// File: tb/tb_bmu_writeback_buffer.sv
// Randomized bench for bmu_writeback_buffer against a queue-based model.
// The bench plays the BMU: its output advances only when the clock enable is high.
module tb_bmu_writeback_buffer;
    import apogeo_pkg::*;

    localparam int DEPTH = 4;
    localparam int TW    = 6;

    typedef struct {
        bit            v;
        bmu_wb_entry_t e;
    } src_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          stall = 1'b0;
    logic          ready = 1'b0;
    data_word_t    bmu_result = '0;
    logic          bmu_valid = 1'b0;
    logic [TW-1:0] bmu_tag = '0;
    logic [4:0]    bmu_dest = '0;
    logic          en;
    logic          full;
    logic          empty;

    bmu_writeback_buffer_if #(.TAG_WIDTH(TW)) wb ();
    assign wb.wb_ready_i = ready;

    bmu_writeback_buffer #(
        .DEPTH     (DEPTH),
        .TAG_WIDTH (TW)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .clear_i      (clear),
        .stall_i      (stall),
        .bmu_result_i (bmu_result),
        .bmu_valid_i  (bmu_valid),
        .bmu_tag_i    (bmu_tag),
        .bmu_dest_i   (bmu_dest),
        .bmu_clk_en_o (en),
        .wb           (wb.master),
        .full_o       (full),
        .empty_o      (empty)
    );

    always #5 clk = ~clk;

    src_t          src[$];
    bmu_wb_entry_t q[$];
    bit            fresh_m;
    bit            hold_m;
    int            n_cmp;
    int            n_bad;
    int            dut_pops;
    int            model_pops;

    task automatic chk(string tag, logic [63:0] got,
                       logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    function automatic src_t mk(bit v, data_word_t r,
                                logic [4:0] d, logic [TW-1:0] t);
        src_t s;
        s.v        = v;
        s.e.result = r;
        s.e.dest   = d;
        s.e.tag    = t;
        return s;
    endfunction

    task automatic load_bmu();
        src_t s;
        if (src.size() != 0) begin
            s          = src.pop_front();
            bmu_valid  = s.v;
            bmu_result = s.e.result;
            bmu_dest   = s.e.dest;
            bmu_tag    = s.e.tag;
        end else begin
            bmu_valid  = 1'b0;
            bmu_result = $urandom;
            bmu_dest   = 5'($urandom);
            bmu_tag    = TW'($urandom);
        end
    endtask

    // Called at posedge+1 with this cycle's ready/stall/clear already set.
    task automatic cycle();
        bit            push_m;
        bit            byp_m;
        bit            vld_m;
        bit            pop_m;
        bit            en_m;
        bmu_wb_entry_t head;
        bmu_wb_entry_t cur;
        #3;
        cur.result = bmu_result;
        cur.dest   = bmu_dest;
        cur.tag    = bmu_tag;
        push_m = bmu_valid && fresh_m && !clear;
        byp_m  = 1'b0;
`ifdef BMU_WB_BYPASS_EN
        byp_m  = (q.size() == 0) && push_m && ready;
`endif
        vld_m = (q.size() != 0) || byp_m;
        en_m  = !stall && !hold_m &&
                (q.size() + int'(push_m) <= DEPTH - 1);
        chk("valid", wb.wb_valid_o, vld_m);
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("clk_en", en, en_m);
        if (vld_m) begin
            head = byp_m ? cur : q[0];
            chk("result", wb.wb_result_o, head.result);
            chk("dest", wb.wb_dest_o, head.dest);
            chk("tag", wb.wb_tag_o, head.tag);
        end
        pop_m = vld_m && ready && !clear;
        if (pop_m) model_pops++;
        if (wb.wb_valid_o && ready && !clear) dut_pops++;
        @(posedge clk);
        #1;
        if (clear) begin
            q.delete();
            fresh_m   = 1'b0;
            hold_m    = 1'b1;
            bmu_valid = 1'b0;
        end else begin
            if (pop_m && !byp_m) void'(q.pop_front());
            if (push_m && !byp_m) q.push_back(cur);
            fresh_m = en_m;
            hold_m  = 1'b0;
            if (en_m) load_bmu();
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int p0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        chk("rst_valid", wb.wb_valid_o, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_en", en, 1'b1);
        run(1);

        // single push, ready high
        ready = 1'b1;
        src.push_back(mk(1'b1, 32'hDEADBEEF, 5'd5, 6'd3));
        p0 = dut_pops;
        run(4);
        chk("single_pops", dut_pops - p0, 1);
        chk("single_empty", empty, 1'b1);

        // fill with ready low, then drain in order
        ready = 1'b0;
        for (int i = 1; i <= 5; i++)
            src.push_back(mk(1'b1, i, 5'(i), TW'(i)));
        run(8);
        chk("fill_full", full, 1'b1);
        chk("fill_en", en, 1'b0);
        ready = 1'b1;
        p0 = dut_pops;
        run(10);
        chk("fill_pops", dut_pops - p0, 5);

        // held valid while the BMU is stalled
        ready = 1'b0;
        src.push_back(mk(1'b1, 32'h0000_1234, 5'd9, 6'd7));
        run(1);
        stall = 1'b1;
        run(3);
        stall = 1'b0;
        ready = 1'b1;
        p0 = dut_pops;
        run(4);
        chk("held_pops", dut_pops - p0, 1);

        // wrap with toggling ready
        for (int i = 0; i < 10; i++)
            src.push_back(mk(1'b1, $urandom, 5'($urandom),
                             TW'($urandom)));
        p0 = dut_pops;
        for (int i = 0; i < 30; i++) begin
            ready = ~ready;
            cycle();
        end
        ready = 1'b1;
        run(6);
        chk("wrap_pops", dut_pops - p0, 10);

        // flush with three entries queued
        ready = 1'b0;
        for (int i = 0; i < 3; i++)
            src.push_back(mk(1'b1, 32'hF00 + i, 5'(i), TW'(i)));
        run(5);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("flush_valid", wb.wb_valid_o, 1'b0);
        chk("flush_empty", empty, 1'b1);
        chk("flush_en0", en, 1'b0);
        cycle();
        chk("flush_en1", en, 1'b1);
        run(2);

        // async reset mid-cycle with two entries queued
        for (int i = 0; i < 2; i++)
            src.push_back(mk(1'b1, 32'hA0 + i, 5'(i), TW'(i)));
        run(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", wb.wb_valid_o, 1'b0);
        chk("arst_empty", empty, 1'b1);
        chk("arst_en", en, 1'b1);
        q.delete();
        src.delete();
        fresh_m   = 1'b0;
        hold_m    = 1'b0;
        bmu_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // empty plus push with ready (bypass when enabled)
        ready = 1'b1;
        src.push_back(mk(1'b1, 32'h5A5A_A5A5, 5'd17, 6'd33));
        run(4);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 7) == 0);
            clear = ($urandom_range(0, 49) == 0);
            if (src.size() < 4)
                src.push_back(mk($urandom_range(0, 3) != 0,
                                 $urandom, 5'($urandom),
                                 TW'($urandom)));
            cycle();
        end
        clear = 1'b0;
        stall = 1'b0;
        ready = 1'b1;
        run(12);
        chk("total_pops", dut_pops, model_pops);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
